// File: rtl/bmp_gray_writer.sv
// Streams 8-bit gray pixels out as a 24-bit BMP byte stream (B=G=R per pixel, rows zero-padded to 4 bytes).
// Define BMP_HEADER_EN to prefix each frame with the 54-byte BMP header; without it only pixel/pad bytes are emitted.
module bmp_gray_writer #(
  parameter int unsigned WIDTH  = 720,
  parameter int unsigned HEIGHT = 540
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic       in_empty,
  input  logic [7:0] in_dout,
  output logic       in_rd_en,
  input  logic       out_full,
  output logic       out_wr_en,
  output logic [7:0] out_din
);

  localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [31:0] ROW_BYTES = 32'(3 * WIDTH);
  localparam logic [31:0] PAD_BYTES = (32'd4 - (ROW_BYTES % 32'd4)) % 32'd4;
  localparam bit          HAS_PAD   = (PAD_BYTES != 32'd0);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [1:0]       PAD_LAST = 2'(PAD_BYTES - 32'd1);

`ifdef BMP_HEADER_EN
  localparam logic [31:0] IMG_SIZE  = 32'(HEIGHT) * (ROW_BYTES + PAD_BYTES);
  localparam logic [31:0] FILE_SIZE = 32'd54 + IMG_SIZE;

  function automatic logic [7:0] le_byte(input logic [31:0] w, input logic [1:0] k);
    return w[{k, 3'b000} +: 8];
  endfunction

  // Every multi-byte field starts at an offset of 2 mod 4, so (idx-2) mod 4 selects the byte within it.
  function automatic logic [7:0] hdr_byte(input logic [5:0] idx);
    logic [1:0] k;
    logic [7:0] b;
    k = idx[1:0] - 2'd2;
    case (idx) inside
      6'd0:            b = 8'h42;
      6'd1:            b = 8'h4D;
      [6'd2:6'd5]:     b = le_byte(FILE_SIZE, k);
      [6'd10:6'd13]:   b = le_byte(32'd54, k);
      [6'd14:6'd17]:   b = le_byte(32'd40, k);
      [6'd18:6'd21]:   b = le_byte(32'(WIDTH), k);
      [6'd22:6'd25]:   b = le_byte(32'(HEIGHT), k);
      [6'd26:6'd29]:   b = le_byte({16'd24, 16'd1}, k);
      [6'd34:6'd37]:   b = le_byte(IMG_SIZE, k);
      [6'd38:6'd45]:   b = le_byte(32'd2835, k);
      default:         b = 8'h00;
    endcase
    return b;
  endfunction
`endif

  typedef enum logic [2:0] {
    IDLE,
`ifdef BMP_HEADER_EN
    HEADER,
`endif
    PIXEL,
    PAD,
    FIN
  } state_t;

  state_t           state, state_nx;
  logic [1:0]       byte_idx, byte_nx;
  logic [COL_W-1:0] col, col_nx;
  logic [ROW_W-1:0] row, row_nx;
  logic [1:0]       pad_cnt, pad_nx;
  logic             end_of_row;
`ifdef BMP_HEADER_EN
  logic [5:0]       hdr_idx, hdr_nx;
`endif

  // State and counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      byte_idx <= 2'd0;
      col      <= '0;
      row      <= '0;
      pad_cnt  <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef BMP_HEADER_EN
      hdr_idx  <= 6'd0;
`endif
    end else begin
      state    <= state_nx;
      byte_idx <= byte_nx;
      col      <= col_nx;
      row      <= row_nx;
      pad_cnt  <= pad_nx;
      busy     <= (state_nx != IDLE);
      done     <= (state_nx == FIN);
`ifdef BMP_HEADER_EN
      hdr_idx  <= hdr_nx;
`endif
    end
  end

  // Next state, counters and the write/pop strobes
  always_comb begin
    state_nx   = state;
    byte_nx    = byte_idx;
    col_nx     = col;
    row_nx     = row;
    pad_nx     = pad_cnt;
    end_of_row = 1'b0;
    out_wr_en  = 1'b0;
    in_rd_en   = 1'b0;
    out_din    = 8'h00;
`ifdef BMP_HEADER_EN
    hdr_nx     = hdr_idx;
`endif

    case (state)
      IDLE: begin
        if (start) begin
`ifdef BMP_HEADER_EN
          state_nx = HEADER;
          hdr_nx   = 6'd0;
`else
          state_nx = PIXEL;
`endif
          byte_nx  = 2'd0;
          col_nx   = '0;
          row_nx   = '0;
          pad_nx   = 2'd0;
        end
      end
`ifdef BMP_HEADER_EN
      HEADER: begin
        out_din = hdr_byte(hdr_idx);
        if (!out_full) begin
          out_wr_en = 1'b1;
          hdr_nx    = hdr_idx + 6'd1;
          if (hdr_idx == 6'd53) state_nx = PIXEL;
        end
      end
`endif
      PIXEL: begin
        out_din = in_dout;
        if (!out_full && !in_empty) begin
          out_wr_en = 1'b1;
          if (byte_idx == 2'd2) begin
            // Pop only on the third copy so a stall mid-pixel keeps the word at the FIFO head
            in_rd_en = 1'b1;
            byte_nx  = 2'd0;
            if (col == COL_LAST) begin
              if (HAS_PAD) begin
                state_nx = PAD;
                pad_nx   = 2'd0;
              end else begin
                end_of_row = 1'b1;
              end
            end else begin
              col_nx = col + COL_W'(1);
            end
          end else begin
            byte_nx = byte_idx + 2'd1;
          end
        end
      end
      PAD: begin
        if (!out_full) begin
          out_wr_en = 1'b1;
          if (pad_cnt == PAD_LAST) end_of_row = 1'b1;
          else                     pad_nx = pad_cnt + 2'd1;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (end_of_row) begin
      if (row == ROW_LAST) begin
        state_nx = FIN;
      end else begin
        row_nx   = row + ROW_W'(1);
        col_nx   = '0;
        state_nx = PIXEL;
      end
    end
  end

endmodule
